chram_wr_sched: RTL and testbench

Write-port scheduler for the overlay character-index RAM. It shares the single RAM write port (address/data/enable) between three independent requesters, such as the tape-progress updater, a text-message writer and a status-icon writer, using round-robin arbitration with a valid/ready handshake. It also contains a built-in screen-clear engine that fills a programmable address range with a fill character and has absolute priority over all requesters. It sits between the requesters and the write port of the character RAM, and produces at most one registered write per clock.

---
 rtl/chram_wr_sched.sv | 158 +++++++++++++++
 tb/tb_chram_wr_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chram_wr_sched.sv
// ---------------------------------------------------------------------------
// chram_wr_sched
//
// Write-port scheduler for the overlay character-index RAM. Three requesters
// share the single RAM write port through round-robin arbitration with a
// valid/ready handshake. A built-in clear engine fills addresses
// 0..CLEAR_LEN-1 with CLEAR_CHAR and has absolute priority over requesters.
// At most one registered write leaves the block per clock.
//
// Ports
//   i_clk      : clock, all state on its rising edge
//   reset_n    : asynchronous active-low reset
//   req_valid  : per-requester write request (bit i = requester i)
//   req_ready  : per-requester accept, combinational, at most one bit high
//   req_addr   : flattened addresses, requester i at [i*AW +: AW]
//   req_data   : flattened data, requester i at [i*DW +: DW]
//   clr_start  : level-sampled clear request (ignored while clearing)
//   clr_busy   : high while the clear engine owns the write port
//   wr_ena     : registered RAM write enable
//   wr_addr    : registered RAM write address
//   wr_data    : registered RAM write data
//   grant_id   : index of the most recently accepted requester
// ---------------------------------------------------------------------------
module chram_wr_sched #(
   parameter int              AW         = 11,
   parameter int              DW         = 8,
   parameter int              CLEAR_LEN  = 2048,
   parameter logic [DW-1:0]   CLEAR_CHAR = 8'h20
) (
   input  logic              i_clk,
   input  logic              reset_n,
   input  logic [2:0]        req_valid,
   output logic [2:0]        req_ready,
   input  logic [3*AW-1:0]   req_addr,
   input  logic [3*DW-1:0]   req_data,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              wr_ena,
   output logic [AW-1:0]     wr_addr,
   output logic [DW-1:0]     wr_data,
   output logic [1:0]        grant_id
);

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_CLEAR = 2'd1
   } state_t;

   // cnt is one bit wider than the address so CLEAR_LEN = 2^AW ends cleanly.
   localparam int            CW         = AW + 1;
   localparam logic [AW:0]   C_CNT_LAST = CW'(CLEAR_LEN - 1);

   state_t          r_state,   w_state_nxt;
   logic [AW:0]     r_cnt,     w_cnt_nxt;
   logic [1:0]      r_last,    w_last_nxt;
   logic            r_busy,    w_busy_nxt;
   logic            r_wr_ena,  w_wr_ena_nxt;
   logic [AW-1:0]   r_wr_addr, w_wr_addr_nxt;
   logic [DW-1:0]   r_wr_data, w_wr_data_nxt;
   logic [1:0]      r_grant,   w_grant_nxt;
   logic [2:0]      w_ready;
   logic [1:0]      w_pick;

   // First valid requester searching from (last+1) mod 3. Only meaningful
   // when at least one request is valid.
   function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                          input logic [2:0] v);
      logic [1:0] id;
      case (last)
         2'd0:    id = v[1] ? 2'd1 : (v[2] ? 2'd2 : 2'd0);
         2'd1:    id = v[2] ? 2'd2 : (v[0] ? 2'd0 : 2'd1);
         default: id = v[0] ? 2'd0 : (v[1] ? 2'd1 : 2'd2);
      endcase
      return id;
   endfunction

   assign w_pick = rr_pick(r_last, req_valid);

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_last_nxt    = r_last;
      w_busy_nxt    = r_busy;
      w_wr_ena_nxt  = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_grant_nxt   = r_grant;
      w_ready       = 3'b000;

      case (r_state)
         ST_ARB: begin
            if (clr_start) begin
               // Clear wins over any valid request this cycle.
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end else if (|req_valid) begin
               w_ready       = 3'b001 << w_pick;
               w_wr_ena_nxt  = 1'b1;
               w_wr_addr_nxt = req_addr[w_pick*AW +: AW];
               w_wr_data_nxt = req_data[w_pick*DW +: DW];
               w_last_nxt    = w_pick;
               w_grant_nxt   = w_pick;
            end
         end
         ST_CLEAR: begin
            w_wr_ena_nxt  = 1'b1;
            w_wr_addr_nxt = r_cnt[AW-1:0];
            w_wr_data_nxt = CLEAR_CHAR;
            w_cnt_nxt     = r_cnt + 1'b1;
            if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = ST_ARB;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            // Unused encoding: fall back to arbitration with the port idle.
            w_state_nxt = ST_ARB;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_ARB;
         r_cnt     <= '0;
         r_last    <= 2'd2;
         r_busy    <= 1'b0;
         r_wr_ena  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_grant   <= 2'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_last    <= w_last_nxt;
         r_busy    <= w_busy_nxt;
         r_wr_ena  <= w_wr_ena_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_grant   <= w_grant_nxt;
      end
   end

   // Held at zero during reset so no requester believes it was accepted.
   assign req_ready = reset_n ? w_ready : 3'b000;
   assign clr_busy  = r_busy;
   assign wr_ena    = r_wr_ena;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign grant_id  = r_grant;

endmodule

// File: tb/tb_chram_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_chram_wr_sched
//
// Self-checking bench for chram_wr_sched with CLEAR_LEN = 16. A small model
// picks the round-robin winner by modular search over the requesters and
// tracks the last granted index and the held write address/data.
// ---------------------------------------------------------------------------
module tb_chram_wr_sched;

   localparam int            AW         = 11;
   localparam int            DW         = 8;
   localparam int            CLEAR_LEN  = 16;
   localparam logic [DW-1:0] CLEAR_CHAR = 8'h20;

   logic              i_clk     = 1'b0;
   logic              reset_n   = 1'b0;
   logic [2:0]        req_valid = 3'b000;
   logic [2:0]        req_ready;
   logic [3*AW-1:0]   req_addr  = '0;
   logic [3*DW-1:0]   req_data  = '0;
   logic              clr_start = 1'b0;
   logic              clr_busy;
   logic              wr_ena;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [1:0]        grant_id;

   chram_wr_sched #(
      .AW(AW), .DW(DW), .CLEAR_LEN(CLEAR_LEN), .CLEAR_CHAR(CLEAR_CHAR)
   ) dut (
      .i_clk(i_clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .clr_start(clr_start), .clr_busy(clr_busy),
      .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .grant_id(grant_id)
   );

   always #5 i_clk = ~i_clk;

   int              errors = 0;
   int              checks = 0;
   int              m_last = 2;
   logic [AW-1:0]   m_addr = '0;
   logic [DW-1:0]   m_data = '0;
   logic [AW-1:0]   a_q [3];
   logic [DW-1:0]   d_q [3];

   // Reference arbitration: first valid index among last+1, last+2, last+3 (mod 3).
   function automatic int model_pick(input logic [2:0] v, input int last);
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (last + k) % 3;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic drive_fields();
      for (int i = 0; i < 3; i++) begin
         req_addr[i*AW +: AW] = a_q[i];
         req_data[i*DW +: DW] = d_q[i];
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         a_q[i] = AW'(i * 300 + 5);
         d_q[i] = DW'(i + 1);
      end
      drive_fields();
      reset_n   = 1'b0;
      req_valid = 3'b111;
      #7;
      checks++;
      if (req_ready !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 000", req_ready);
      end
      checks++;
      if ({wr_ena, wr_addr, wr_data, clr_busy, grant_id} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ena=%b addr=%0d data=%h busy=%b gid=%0d expected all 0",
                  wr_ena, wr_addr, wr_data, clr_busy, grant_id);
      end
      req_valid = 3'b000;
      step();
      #2 reset_n = 1'b1;
      m_last = 2;
      step();
      checks++;
      if (wr_ena !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: wr_ena got %b expected 0", wr_ena);
      end
   endtask

   task automatic test_round_robin();
      int g;
      for (int i = 0; i < 3; i++) begin
         a_q[i] = AW'(i * 100 + $urandom_range(0, 99));
         d_q[i] = DW'($urandom);
      end
      drive_fields();
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         g = model_pick(req_valid, m_last);
         checks++;
         if (req_ready !== (3'b001 << g)) begin
            errors++;
            $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 3'b001 << g);
         end
         step();
         checks++;
         if ({wr_ena, wr_addr, wr_data, grant_id} !== {1'b1, a_q[g], d_q[g], 2'(g)}) begin
            errors++;
            $display("FAIL rr_write[%0d]: got ena=%b addr=%0d data=%h gid=%0d expected 1/%0d/%h/%0d",
                     k, wr_ena, wr_addr, wr_data, grant_id, a_q[g], d_q[g], g);
         end
         checks++;
         if (grant_id !== 2'(k % 3)) begin
            errors++;
            $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_id, k % 3);
         end
         m_last = g;
         m_addr = a_q[g];
         m_data = d_q[g];
         a_q[g] = AW'(g * 100 + $urandom_range(0, 99));
         d_q[g] = DW'($urandom);
         drive_fields();
      end
      req_valid = 3'b000;
   endtask

   task automatic test_single();
      a_q[1] = AW'(147);
      d_q[1] = 8'h7F;
      drive_fields();
      req_valid = 3'b010;
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++;
         $display("FAIL single_ready: got %b expected 010", req_ready);
      end
      step();
      checks++;
      if ({wr_ena, wr_addr, wr_data, grant_id} !== {1'b1, 11'd147, 8'h7F, 2'd1}) begin
         errors++;
         $display("FAIL single_write: got ena=%b addr=%0d data=%h gid=%0d expected 1/147/7f/1",
                  wr_ena, wr_addr, wr_data, grant_id);
      end
      m_last = 1; m_addr = 11'd147; m_data = 8'h7F;
      req_valid = 3'b000;
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
         errors++;
         $display("FAIL single_ready_idle: got %b expected 000", req_ready);
      end
      step();
      checks++;
      if ({wr_ena, wr_addr, wr_data} !== {1'b0, 11'd147, 8'h7F}) begin
         errors++;
         $display("FAIL single_hold: got ena=%b addr=%0d data=%h expected 0/147/7f",
                  wr_ena, wr_addr, wr_data);
      end
   endtask

   task automatic test_random();
      int g;
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!req_valid[i] && c < 50 && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               a_q[i] = AW'($urandom);
               d_q[i] = DW'($urandom);
            end
         end
         drive_fields();
         #1;
         g = model_pick(req_valid, m_last);
         checks++;
         if (req_ready !== ((g < 0) ? 3'b000 : (3'b001 << g))) begin
            errors++;
            $display("FAIL rand_ready[%0d]: got %b valid %b last %0d", c, req_ready, req_valid, m_last);
         end
         step();
         if (g >= 0) begin
            m_last = g; m_addr = a_q[g]; m_data = d_q[g];
            req_valid[g] = 1'b0;
         end
         checks++;
         if ({wr_ena, wr_addr, wr_data, grant_id} !== {(g >= 0), m_addr, m_data, 2'(m_last)}) begin
            errors++;
            $display("FAIL rand_write[%0d]: got ena=%b addr=%0d data=%h gid=%0d expected %b/%0d/%h/%0d",
                     c, wr_ena, wr_addr, wr_data, grant_id, (g >= 0), m_addr, m_data, m_last);
         end
      end
      req_valid = 3'b000;
   endtask

   task automatic test_clear_priority();
      int g;
      a_q[0] = AW'(339);
      d_q[0] = DW'($urandom);
      drive_fields();
      req_valid = 3'b001;
      clr_start = 1'b1;
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
         errors++;
         $display("FAIL clr_start_ready: got %b expected 000", req_ready);
      end
      step();
      clr_start = 1'b0;
      checks++;
      if ({clr_busy, wr_ena} !== 2'b10) begin
         errors++;
         $display("FAIL clr_enter: got busy=%b ena=%b expected busy=1 ena=0", clr_busy, wr_ena);
      end
      for (int n = 0; n < CLEAR_LEN; n++) begin
         #1;
         checks++;
         if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL clr_ready[%0d]: got %b expected 000", n, req_ready);
         end
         step();
         checks++;
         if ({wr_ena, wr_addr, wr_data, clr_busy} !== {1'b1, AW'(n), CLEAR_CHAR, (n != CLEAR_LEN - 1)}) begin
            errors++;
            $display("FAIL clr_write[%0d]: got ena=%b addr=%0d data=%h busy=%b expected 1/%0d/%h/%b",
                     n, wr_ena, wr_addr, wr_data, clr_busy, n, CLEAR_CHAR, (n != CLEAR_LEN - 1));
         end
      end
      #1;
      g = model_pick(req_valid, m_last);
      checks++;
      if (req_ready !== (3'b001 << g)) begin
         errors++;
         $display("FAIL clr_after_ready: got %b expected %b", req_ready, 3'b001 << g);
      end
      step();
      checks++;
      if ({wr_ena, wr_addr, wr_data, grant_id} !== {1'b1, 11'd339, d_q[0], 2'd0}) begin
         errors++;
         $display("FAIL clr_after_write: got ena=%b addr=%0d data=%h gid=%0d expected 1/339/%h/0",
                  wr_ena, wr_addr, wr_data, grant_id, d_q[0]);
      end
      m_last = 0; m_addr = 11'd339; m_data = d_q[0];
      req_valid = 3'b000;
   endtask

   task automatic test_clear_restart();
      int count;
      count = 0;
      clr_start = 1'b1;
      step();
      for (int c = 0; c < CLEAR_LEN + 4; c++) begin
         clr_start = (c >= 3 && c <= 8);
         step();
         if (wr_ena === 1'b1) begin
            checks++;
            if ({wr_addr, wr_data} !== {AW'(count), CLEAR_CHAR}) begin
               errors++;
               $display("FAIL restart_write[%0d]: got addr=%0d data=%h expected %0d/%h",
                        count, wr_addr, wr_data, count, CLEAR_CHAR);
            end
            count++;
         end
      end
      clr_start = 1'b0;
      checks++;
      if (count !== CLEAR_LEN) begin
         errors++;
         $display("FAIL restart_count: got %0d writes expected %0d", count, CLEAR_LEN);
      end
      checks++;
      if (clr_busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_busy: got %b expected 0", clr_busy);
      end
   endtask

   task automatic test_async_reset();
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      for (int n = 0; n < 5; n++) step();
      checks++;
      if ({wr_ena, wr_addr, clr_busy} !== {1'b1, 11'd4, 1'b1}) begin
         errors++;
         $display("FAIL arst_pre: got ena=%b addr=%0d busy=%b expected 1/4/1", wr_ena, wr_addr, clr_busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({wr_ena, clr_busy} !== 2'b00) begin
         errors++;
         $display("FAIL arst_immediate: got ena=%b busy=%b expected 0/0", wr_ena, clr_busy);
      end
      step();
      #2 reset_n = 1'b1;
      m_last = 2;
      step();
      checks++;
      if ({wr_ena, clr_busy} !== 2'b00) begin
         errors++;
         $display("FAIL arst_no_resume: got ena=%b busy=%b expected 0/0", wr_ena, clr_busy);
      end
      for (int i = 0; i < 3; i++) begin
         a_q[i] = AW'($urandom);
         d_q[i] = DW'($urandom);
      end
      drive_fields();
      req_valid = 3'b111;
      #1;
      checks++;
      if (req_ready !== (3'b001 << model_pick(req_valid, m_last))) begin
         errors++;
         $display("FAIL arst_ready: got %b expected 001", req_ready);
      end
      step();
      checks++;
      if ({wr_ena, wr_addr, wr_data, grant_id} !== {1'b1, a_q[0], d_q[0], 2'd0}) begin
         errors++;
         $display("FAIL arst_first_write: got ena=%b addr=%0d data=%h gid=%0d expected 1/%0d/%h/0",
                  wr_ena, wr_addr, wr_data, grant_id, a_q[0], d_q[0]);
      end
      req_valid = 3'b000;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_random();
      test_clear_priority();
      test_clear_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
